// File: rtl/data_memory_if.sv
// ---------------------------------------------------------------------------
// data_memory_if
//
// Serialized memory port between the tinyGPU N-core memory controller and
// the shared data memory. The data path is fixed at 16 bits.
//
// Signals:
//   addr_mem      - word address from the controller
//   data_to_mem   - write data from the controller
//   wren          - 1 = write at the next rising edge, 0 = read
//   data_from_mem - combinational read data back to the controller
//
// Modports:
//   master - controller side (drives address/data/wren, receives read data)
//   slave  - memory side
// ---------------------------------------------------------------------------
interface data_memory_if;
    logic [15:0] addr_mem;
    logic [15:0] data_to_mem;
    logic        wren;
    logic [15:0] data_from_mem;

    modport master (
        output addr_mem,
        output data_to_mem,
        output wren,
        input  data_from_mem
    );

    modport slave (
        input  addr_mem,
        input  data_to_mem,
        input  wren,
        output data_from_mem
    );
endinterface

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//
// Single-port word-addressed data memory serving the memory controller's
// serialized port. Reads are combinational, writes happen on the rising edge.
// Adds out-of-range detection (sticky err_oob), saturating read/write
// counters and a side-effect-free debug read port.
//
// Optional feature, macro DATA_MEM_CLEAR_EN:
//   defined   - after reset a CLEAR/READY FSM sweeps zeros through every word,
//               one word per cycle; mem_busy is high while it runs and all
//               controller accesses are ignored.
//   undefined - no sweep; mem_busy is tied low and contents survive reset.
//
// Parameters:
//   ADDR_W - implemented address bits, depth = 2**ADDR_W words
//   DATA_W - word width, must be 16 to match the controller data path
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   reset       - synchronous active-high reset
//   bus         - controller memory port (slave side)
//   mem_busy    - clear sweep in progress
//   err_oob     - sticky out-of-range access flag
//   dbg_addr    - debug read address
//   dbg_data    - debug read data (0 when dbg_addr is out of range)
//   stat_reads  - accepted reads, saturating at 16'hFFFF
//   stat_writes - accepted writes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    data_memory_if.slave bus,
    output logic         mem_busy,
    output logic         err_oob,
    input  logic [15:0]  dbg_addr,
    output logic [15:0]  dbg_data,
    output logic [15:0]  stat_reads,
    output logic [15:0]  stat_writes
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] bus_idx;
    logic [ADDR_W-1:0] dbg_idx;
    logic              bus_oob;
    logic              dbg_oob;

    logic              acc;
    logic              wr_acc;
    logic              rd_acc;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [15:0]       stat_reads_q;
    logic [15:0]       stat_reads_d;
    logic [15:0]       stat_writes_q;
    logic [15:0]       stat_writes_d;
    logic              err_oob_q;
    logic              err_oob_d;

    assign bus_idx = bus.addr_mem[ADDR_W-1:0];
    assign dbg_idx = dbg_addr[ADDR_W-1:0];

    // Any set bit above the implemented range makes the address out of range.
    generate
        if (ADDR_W < 16) begin : g_oob
            assign bus_oob = |bus.addr_mem[15:ADDR_W];
            assign dbg_oob = |dbg_addr[15:ADDR_W];
        end else begin : g_no_oob
            assign bus_oob = 1'b0;
            assign dbg_oob = 1'b0;
        end
    endgenerate

`ifdef DATA_MEM_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] sweep_q;
    logic [ADDR_W-1:0] sweep_d;
    logic              clr_we;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state logic: one word per cycle, leave CLEAR once the last word
    // is written.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == CLEAR) begin
            sweep_d = sweep_q + ADDR_W'(1);
            if (&sweep_q) begin
                state_d = READY;
            end
        end
    end

    // Outputs: reset outranks the sweep write in the same cycle.
    always_comb begin
        mem_busy = (state_q == CLEAR);
        clr_we   = (state_q == CLEAR) && !reset;
    end
`else
    assign mem_busy = 1'b0;
`endif

    assign acc    = !mem_busy && !bus_oob;
    assign wr_acc = acc && bus.wren && !reset;
    assign rd_acc = acc && !bus.wren;

    // Single write port shared by controller writes and the clear sweep;
    // the two never overlap because the sweep keeps mem_busy high.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus_idx;
        mem_wdata = bus.data_to_mem;
        if (wr_acc) begin
            mem_we = 1'b1;
        end
`ifdef DATA_MEM_CLEAR_EN
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational reads see the pre-edge contents, so a read-during-write
    // to the same word returns the old value.
    assign bus.data_from_mem = acc ? mem_q[bus_idx] : '0;
    assign dbg_data          = dbg_oob ? '0 : mem_q[dbg_idx];

    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        err_oob_d     = err_oob_q;
        if (rd_acc && (stat_reads_q != 16'hFFFF)) begin
            stat_reads_d = stat_reads_q + 16'd1;
        end
        if (wr_acc && (stat_writes_q != 16'hFFFF)) begin
            stat_writes_d = stat_writes_q + 16'd1;
        end
        if (!mem_busy && bus_oob) begin
            err_oob_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            err_oob_q     <= 1'b0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            err_oob_q     <= err_oob_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign err_oob     = err_oob_q;

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
//
// Self-checking bench for data_memory with ADDR_W=4 (16 words). A reference
// model tracks memory contents, busy window, counters and the sticky error
// flag from the behavioural rules. Works with or without DATA_MEM_CLEAR_EN.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_data_memory;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_busy;
    logic        err_oob;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] stat_reads;
    logic [15:0] stat_writes;

    data_memory_if bus_if ();

    data_memory #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if.slave),
        .mem_busy    (mem_busy),
        .err_oob     (err_oob),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes)
    );

    always #5 clk = ~clk;

`ifdef DATA_MEM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    // Reference model
    int          m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_busy_left;
    int          m_reads;
    int          m_writes;
    bit          m_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic [15:0] exp_reads;
        logic [15:0] exp_writes;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    function automatic bit is_oob(input logic [15:0] a);
        return a >= 16'(DEPTH);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] dbg);
        reset              = r;
        bus_if.wren        = w;
        bus_if.addr_mem    = a;
        bus_if.data_to_mem = d;
        dbg_addr           = dbg;
        #1;
    endtask

    // Compare every observable output with what the model predicts.
    task automatic check_model();
        logic [15:0] a;
        logic [15:0] da;
        a  = bus_if.addr_mem;
        da = dbg_addr;
        chk("mem_busy", 16'(mem_busy), 16'(m_busy_left > 0));
        chk("err_oob", 16'(err_oob), 16'(m_err));
        chk("stat_reads", stat_reads, 16'(m_reads));
        chk("stat_writes", stat_writes, 16'(m_writes));
        if (m_busy_left > 0 || is_oob(a)) begin
            chk("data_from_mem_zero", bus_if.data_from_mem, 16'h0000);
        end else if (m_known[a[3:0]]) begin
            chk("data_from_mem", bus_if.data_from_mem, 16'(m_mem[a[3:0]]));
        end
        if (is_oob(da)) begin
            chk("dbg_data_oob", dbg_data, 16'h0000);
        end else if (m_known[da[3:0]]) begin
            chk("dbg_data", dbg_data, 16'(m_mem[da[3:0]]));
        end
        $display("cyc rst=%0b wr=%0b addr=%h din=%h dout=%h busy=%0b err=%0b rd=%0d wr=%0d",
                 reset, bus_if.wren, a, bus_if.data_to_mem, bus_if.data_from_mem,
                 mem_busy, err_oob, stat_reads, stat_writes);
    endtask

    // Advance one clock and apply the behavioural rules to the model.
    task automatic step();
        logic [15:0] a;
        @(posedge clk);
        a = bus_if.addr_mem;
        if (reset) begin
            m_reads  = 0;
            m_writes = 0;
            m_err    = 1'b0;
            if (CLEAR_EN) begin
                m_busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i]   = 0;
                    m_known[i] = 1'b1;
                end
            end
        end else if (is_oob(a)) begin
            m_err = 1'b1;
        end else if (bus_if.wren) begin
            m_mem[a[3:0]]   = int'(bus_if.data_to_mem);
            m_known[a[3:0]] = 1'b1;
            if (m_writes < 65535) m_writes++;
        end else begin
            if (m_reads < 65535) m_reads++;
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] dbg);
        drive(r, w, a, d, dbg);
        check_model();
        step();
    endtask

    // Idle until mem_busy falls; returns the number of busy cycles seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (mem_busy && n < 40) begin
            cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
            n++;
        end
        if (mem_busy) begin
            $display("FAIL busy_timeout: mem_busy still %0b after %0d cycles", mem_busy, n);
            n_total++;
        end
    endtask

    initial begin
        int n;
        m_busy_left = 0;
        m_reads     = 0;
        m_writes    = 0;
        m_err       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 0;
            m_known[i] = 1'b0;
        end

        reset              = 1'b1;
        bus_if.wren        = 1'b0;
        bus_if.addr_mem    = 16'h0000;
        bus_if.data_to_mem = 16'h0000;
        dbg_addr           = 16'h0000;
        @(negedge clk);

        // Reset for one cycle, then check the post-reset state.
        cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        chk("rst_reads", stat_reads, 16'h0000);
        chk("rst_writes", stat_writes, 16'h0000);
        chk("rst_err", 16'(err_oob), 16'h0000);
        chk("rst_busy", 16'(mem_busy), 16'(CLEAR_EN));

        if (CLEAR_EN) begin
            // Busy window with a locked-out write to address 3 in its first cycle.
            n = 0;
            while (mem_busy && n < 40) begin
                cycle(1'b0, n == 0, 16'h0003, 16'h1234, 16'h0000);
                n++;
            end
            chk("busy_cycles", 16'(n), 16'd16);
            chk("lockout_writes", stat_writes, 16'h0000);
            chk("sweep_reads", stat_reads, 16'h0000);
            for (int i = 0; i < DEPTH; i++) begin
                dbg_addr = 16'(i);
                #1;
                chk("sweep_zero", dbg_data, 16'h0000);
            end
            bus_if.wren     = 1'b0;
            bus_if.addr_mem = 16'h0003;
            #1;
            chk("lockout_addr3", bus_if.data_from_mem, 16'h0000);

            // Reset at sweep step 7 restarts a full 16-cycle sweep.
            cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
            for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
            cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
            wait_ready(n);
            chk("midsweep_busy_cycles", 16'(n), 16'd16);
        end else begin
            // No sweep: load every word, then reset (contents must survive).
            for (int i = 0; i < DEPTH; i++)
                cycle(1'b0, 1'b1, 16'(i), 16'($urandom), 16'(i));
            cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        end

        // Directed table: expectations are the values seen before each edge.
        tbl[0]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 16'd0, 16'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0005, 16'h1111, 1'b1, 16'hBEEF, 16'd1, 16'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1111, 16'd1, 16'd2, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0, 16'h0000, 16'd2, 16'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0013, 16'hAAAA, 1'b1, 16'h0000, 16'd2, 16'd3, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0013, 16'h0000, 1'b1, 16'h0000, 16'd2, 16'd3, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h3333, 16'd2, 16'd3, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 16'hFF05, 16'h7777, 1'b1, 16'h0000, 16'd3, 16'd3, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1111, 16'd3, 16'd3, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 16'h0005, 16'hDEAD, 1'b1, 16'h1111, 16'd4, 16'd3, 1'b1};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].addr);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), bus_if.data_from_mem, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_reads", i), stat_reads, tbl[i].exp_reads);
            chk($sformatf("tbl%0d_writes", i), stat_writes, tbl[i].exp_writes);
            chk($sformatf("tbl%0d_err", i), 16'(err_oob), 16'(tbl[i].exp_err));
            check_model();
            step();
        end

        // Reset dropped the concurrent write; model decides retained vs cleared.
        chk("post_rst_err", 16'(err_oob), 16'h0000);
        wait_ready(n);
        cycle(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0005);
        cycle(1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0003);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic [15:0] da;
            a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16, 65535))
                                             : 16'($urandom_range(0, 15));
            da = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16, 65535))
                                             : 16'($urandom_range(0, 15));
            cycle($urandom_range(0, 99) == 0, 1'(($urandom_range(0, 1))), a,
                  16'($urandom), da);
        end

        // Saturation: preload the read counter near the top, then read.
        wait_ready(n);
        drive(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000);
        force dut.stat_reads_q = 16'hFFFE;
        #1;
        release dut.stat_reads_q;
        m_reads = 65534;
        check_model();
        step();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'(i + 1), 16'h0000, 16'h0000);
        drive(1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0000);
        chk("sat_reads", stat_reads, 16'hFFFF);
        check_model();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/data_memory.md
# data_memory

Single-port word-addressed data memory for the tinyGPU shared data path. It sits directly downstream of the N-core memory controller and serves the controller's serialized memory port (`addr_mem`, `data_to_mem`, `wren`, `data_from_mem`). It adds a post-reset clear sweep with a busy flag, out-of-range address detection, saturating access counters, and a read-only debug port for the host/testbench.

## Interface
Parameters:
- `ADDR_W`, default 8, number of implemented address bits; depth = 2**ADDR_W words.
- `DATA_W`, default 16, word width; must equal the controller's 16-bit data path.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — synchronous, active-high.
- `addr_mem` input 16 — word address from the controller.
- `data_to_mem` input 16 — write data from the controller.
- `wren` input 1 — 1 = write `data_to_mem` to `addr_mem` at the next rising edge; 0 = read.
- `data_from_mem` output 16 — read data for `addr_mem`.
- `mem_busy` output 1 — high while the clear sweep runs; accesses are ignored.
- `err_oob` output 1 — sticky flag; set when an access uses an address ≥ depth.
- `dbg_addr` input 16 — debug read address.
- `dbg_data` output 16 — debug read data.
- `stat_reads` output 16 — count of accepted reads, saturating at 16'hFFFF.
- `stat_writes` output 16 — count of accepted writes, saturating at 16'hFFFF.

## Operation
- Storage: array of 2**ADDR_W words, each DATA_W bits.
- Address decode: `addr_mem[ADDR_W-1:0]` indexes the array. The access is out of bounds (OOB) when any of `addr_mem[15:ADDR_W]` is nonzero.
- Reads are asynchronous. `data_from_mem` = mem[addr_mem], or 0 when OOB or when `mem_busy` = 1.
- Writes happen at the rising edge when `wren`=1, `mem_busy`=0, and the address is not OOB.
- An OOB write does not modify the array.
- Accepted access: `mem_busy`=0 and address not OOB.
  - `stat_writes` increments on an accepted write cycle.
  - `stat_reads` increments on an accepted read cycle (`wren`=0).
  - Both counters saturate at 16'hFFFF.
- `err_oob` is set on any cycle with `mem_busy`=0 and an OOB address, whether read or write. It is cleared only by `reset`.
- Debug port: `dbg_data` = mem[dbg_addr[ADDR_W-1:0]] combinationally, or 0 if `dbg_addr` is OOB. It has no side effects on counters or flags.
- State machine (when the clear feature is compiled in):
  - States are `CLEAR` and `READY`.
  - `reset` forces `CLEAR` and sets the sweep counter to 0.
  - In `CLEAR`, each cycle writes 0 to mem[sweep], then increments sweep.
  - When sweep = depth-1 and that word is written, the FSM moves to `READY`.
  - `READY` is held until the next `reset`.

## Timing
- Values after reset (the cycle after `reset` is sampled high):
  - `stat_reads` = 0, `stat_writes` = 0, `err_oob` = 0.
  - With the clear feature, `mem_busy` = 1.
  - Without the clear feature, `mem_busy` = 0.
- Clear sweep takes exactly 2**ADDR_W cycles. `mem_busy` falls on the edge that writes the last word, so the first access is accepted 2**ADDR_W cycles after `reset` deasserts.
- Read latency is 0 cycles (combinational). The controller captures `data_from_mem` at its next rising edge.
- Write followed by read of the same address on the next cycle returns the new data.
- Read-during-write to the same address in one cycle returns the old contents. The new value is visible after the edge.
- `reset` asserted mid-sweep restarts the sweep at address 0.
- `reset` asserted during normal operation:
  - With the clear feature, the FSM re-enters `CLEAR`.
  - Without it, memory contents are retained and only the counters and flags clear.
- `reset` has priority over any concurrent write in the same cycle. The write is dropped.

## Configuration
- Macro: `DATA_MEM_CLEAR_EN`.
- Defined:
  - The `CLEAR`/`READY` FSM and sweep counter are built.
  - `mem_busy` behaves as described above.
  - Memory is all-zero once `mem_busy` falls.
- Undefined:
  - No FSM or sweep counter is built.
  - `mem_busy` is tied to 0.
  - Memory contents after reset are undefined (X in simulation) until written.
  - Accesses are accepted on the first cycle after `reset` deasserts.

## Test plan
- Clear sweep (`DATA_MEM_CLEAR_EN`, ADDR_W=4): hold `reset` 1 cycle, then release → `mem_busy`=1 for exactly 16 cycles. Afterwards `dbg_data`=0 for all 16 addresses. Counters stay 0 throughout.
- Write then read back:
  - Write 16'hBEEF to address 5, then read address 5 on the next cycle → `data_from_mem`=16'hBEEF.
  - Expected counts: `stat_writes`=1, `stat_reads`=1.
- Busy lockout: issue `wren`=1, address 3, data 16'h1234 during the sweep → the write is ignored, address 3 reads 0 after the sweep, and `stat_writes`=0.
- Out of range (ADDR_W=4):
  - Write 16'hAAAA to address 16'h0013 → `err_oob`=1, address 3 unchanged, `data_from_mem`=0 while the address is presented, `stat_writes` unchanged.
  - `err_oob` stays 1 until `reset`.
- Reset mid-sweep: assert `reset` at sweep step 7 → the sweep restarts at 0 and `mem_busy` stays high for a full 16 cycles after release.
- Counter saturation: force `stat_reads` to 16'hFFFE, then perform 3 accepted reads → `stat_reads`=16'hFFFF.
